// File: rtl/bits4_sub_seq_ctrl.sv
// Sequenced 4-bit signed subtractor: handshaked operands, BPC-bit-per-cycle ripple,
// sign/BCD result code. Define OP_COUNT_EN to add the op_count completion counter.
module bits4_sub_seq_ctrl #(
    parameter int unsigned BPC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] s,
    output logic       busy
`ifdef OP_COUNT_EN
    ,
    output logic [7:0] op_count
`endif
);

    typedef enum logic [1:0] {IDLE, SUB, CONV, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  a1_q, a1_d;
    logic [4:0]  b1_q, b1_d;
    logic [4:0]  m_q, m_d;
    logic        carry_q, carry_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  s_q, s_d;
    logic        out_valid_q, out_valid_d;

    logic        c;
    int unsigned idx;
    logic [2:0]  sel;
    logic [3:0]  mag;
    logic        tens;
    logic [3:0]  ones;

    // -16 is unreachable, so the magnitude always fits in the low nibble.
    always_comb begin
        mag  = m_q[4] ? 4'(~m_q[3:0] + 4'd1) : m_q[3:0];
        tens = (mag >= 4'd10);
        ones = tens ? 4'(mag - 4'd10) : mag;
    end

    always_comb begin
        state_d     = state_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        m_d         = m_q;
        carry_d     = carry_q;
        bit_cnt_d   = bit_cnt_q;
        s_d         = s_q;
        out_valid_d = out_valid_q;
        c           = carry_q;
        idx         = 0;
        sel         = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a1_d      = {a[3], a};
                    b1_d      = {~b[3], ~b};
                    carry_d   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SUB;
                end
            end
            SUB: begin
                for (int unsigned i = 0; i < BPC; i++) begin
                    idx = 32'(bit_cnt_q) + i;
                    if (idx < 5) begin
                        sel      = 3'(idx);
                        m_d[sel] = a1_q[sel] ^ b1_q[sel] ^ c;
                        c        = (a1_q[sel] & b1_q[sel]) | (c & (a1_q[sel] ^ b1_q[sel]));
                    end
                end
                carry_d   = c;
                bit_cnt_d = bit_cnt_q + 3'(BPC);
                if (bit_cnt_d >= 3'd5) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                s_d         = {m_q[4], tens, ones};
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a1_q        <= '0;
            b1_q        <= '0;
            m_q         <= '0;
            carry_q     <= 1'b0;
            bit_cnt_q   <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            m_q         <= m_d;
            carry_q     <= carry_d;
            bit_cnt_q   <= bit_cnt_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef OP_COUNT_EN
    logic [7:0] op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (out_valid_q && out_ready) begin
            op_count_q <= op_count_q + 8'd1;
        end
    end

    assign op_count = op_count_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign s         = s_q;

endmodule

// File: tb/tb_bits4_sub_seq_ctrl.sv
// Directed bench for bits4_sub_seq_ctrl: a BPC=1 instance for the vector table and
// corner sequences, plus a BPC=5 instance for back-to-back two-edge latency.
module tb_bits4_sub_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;

    logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic       in_ready1, out_valid1, busy1;
    logic [5:0] s1;

    logic       in_valid5 = 1'b0, out_ready5 = 1'b0;
    logic       in_ready5, out_valid5, busy5;
    logic [5:0] s5;
`ifdef OP_COUNT_EN
    logic [7:0] op_count1, op_count5;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bits4_sub_seq_ctrl #(.BPC(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready1),
        .s(s1), .busy(busy1)
`ifdef OP_COUNT_EN
        , .op_count(op_count1)
`endif
    );

    bits4_sub_seq_ctrl #(.BPC(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .a(a), .b(b), .out_valid(out_valid5), .out_ready(out_ready5),
        .s(s5), .busy(busy5)
`ifdef OP_COUNT_EN
        , .op_count(op_count5)
`endif
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [5:0] exp_s;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one operation; hold>0 keeps out_ready low in DONE that many cycles.
    task automatic run_op(input bit sel, input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic [5:0] es, input int lat, input int hold, input string name);
        int edges;
        int rdy_bad;
        int unstable;
        @(negedge clk);
        a = ta;
        b = tb_v;
        if (sel) in_valid5 = 1'b1; else in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid5 = 1'b0;
        a = ~ta;
        b = ~tb_v;
        edges   = 0;
        rdy_bad = 0;
        while (!(sel ? out_valid5 : out_valid1) && edges < 20) begin
            if (sel ? in_ready5 : in_ready1) rdy_bad++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({name, " latency"}, 32'(edges), 32'(lat));
        check({name, " in_ready low while busy"}, 32'(rdy_bad), 32'd0);
        check({name, " s"}, 32'(sel ? s5 : s1), 32'(es));
        if (hold > 0) begin
            unstable = 0;
            for (int k = 0; k < hold; k++) begin
                if (sel) in_valid5 = ~in_valid5; else in_valid1 = ~in_valid1;
                a = 4'($urandom_range(15));
                b = 4'($urandom_range(15));
                @(posedge clk);
                @(negedge clk);
                if ((sel ? s5 : s1) !== es || (sel ? out_valid5 : out_valid1) !== 1'b1)
                    unstable++;
            end
            in_valid1 = 1'b0;
            in_valid5 = 1'b0;
            check({name, " backpressure stable"}, 32'(unstable), 32'd0);
        end
        if (sel) out_ready5 = 1'b1; else out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 1'b0;
        out_ready5 = 1'b0;
        check({name, " out_valid drop"}, 32'(sel ? out_valid5 : out_valid1), 32'd0);
        check({name, " idle after handshake"},
              {30'd0, (sel ? in_ready5 : in_ready1), (sel ? busy5 : busy1)}, 32'b10);
        check({name, " s held"}, 32'(sel ? s5 : s1), 32'(es));
    endtask

    initial begin
        int stale;
        vecs[0]  = '{4'h7, 4'h8, 6'b010101};
        vecs[1]  = '{4'h8, 4'h7, 6'b110101};
        vecs[2]  = '{4'h3, 4'h5, 6'b100010};
        vecs[3]  = '{4'h0, 4'h0, 6'b000000};
        vecs[4]  = '{4'h5, 4'h3, 6'b000010};
        vecs[5]  = '{4'hD, 4'h4, 6'b100111};
        vecs[6]  = '{4'h6, 4'hA, 6'b010010};
        vecs[7]  = '{4'hF, 4'hF, 6'b000000};
        vecs[8]  = '{4'h8, 4'h8, 6'b000000};
        vecs[9]  = '{4'h2, 4'h9, 6'b001001};
        vecs[10] = '{4'h9, 4'h3, 6'b110000};
        vecs[11] = '{4'h4, 4'hA, 6'b010000};

        #12;
        check("reset in_ready", 32'(in_ready1), 32'd1);
        check("reset out_valid", 32'(out_valid1), 32'd0);
        check("reset s", 32'(s1), 32'd0);
        check("reset busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].exp_s, 6, 0, $sformatf("vec%0d", i));

        run_op(1'b0, 4'h9, 4'h3, 6'b110000, 6, 10, "backpressure");
        run_op(1'b0, 4'h3, 4'h5, 6'b100010, 6, 0, "after backpressure");

        // Abort an operation two bits into SUB.
        @(negedge clk);
        a = 4'h7;
        b = 4'h8;
        in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midsub reset outputs",
              {24'd0, in_ready1, out_valid1, s1}, {24'd0, 1'b1, 1'b0, 6'd0});
        check("midsub reset busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) stale++;
        end
        check("no stale result after reset", 32'(stale), 32'd0);
        run_op(1'b0, 4'h2, 4'h9, 6'b001001, 6, 0, "after reset");

`ifdef OP_COUNT_EN
        check("op_count5 start", 32'(op_count5), 32'd0);
`endif
        run_op(1'b1, 4'h7, 4'h8, 6'b010101, 2, 0, "bpc5 op1");
        run_op(1'b1, 4'h8, 4'h7, 6'b110101, 2, 0, "bpc5 op2");
        run_op(1'b1, 4'hD, 4'h4, 6'b100111, 2, 0, "bpc5 op3");
`ifdef OP_COUNT_EN
        check("op_count5 after 3", 32'(op_count5), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
